password_ctrl: RTL and testbench

Sequencing controller for the 4-digit password lock on the DE-board. It collects digits keyed on SW[3:0] with the load button and compares them against a stored, user-changeable code. Failed attempts are counted, and the keypad locks out for a fixed time after too many failures. HEX3..HEX0 show entry progress and status.

---
 rtl/password_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_password_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/password_ctrl.sv
// Four-digit password lock sequencer: digit collection, code compare, failure
// counting with timed lockout, and seven-segment status display.
module password_ctrl #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       change,
  input  logic [3:0] SW,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int unsigned   LW         = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_INIT  = LW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);
  localparam logic [6:0]    BLANK      = 7'h7F;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_NEWCODE,
    ST_LOCKOUT
  } state_t;

  state_t          state;
  logic [15:0]     code;
  logic [15:0]     entry;
  logic [1:0]      idx;
  logic [2:0]      fail_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            load_q;
  logic            press;
  logic [2:0]      fail_next;

  assign press     = load & ~load_q;
  assign fail_next = fail_cnt + 3'd1;

  // Slot 0 is the leftmost (most significant) nibble.
  function automatic logic [15:0] put_digit(input logic [15:0] v, input logic [1:0] i,
                                            input logic [3:0] d);
    logic [15:0] r;
    r = v;
    case (i)
      2'd0: r[15:12] = d;
      2'd1: r[11:8]  = d;
      2'd2: r[7:4]   = d;
      default: r[3:0] = d;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTRY;
      code     <= CODE;
      entry    <= '0;
      idx      <= '0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= load;
      case (state)
        ST_ENTRY: begin
          if (press) begin
            entry <= put_digit(entry, idx, SW);
            idx   <= idx + 2'd1;
            if (idx == 2'd3) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (entry == code) begin
            state    <= ST_OPEN;
            fail_cnt <= '0;
          end else begin
            fail_cnt <= fail_next;
            if (fail_next == FAIL_LIMIT) begin
              state    <= ST_LOCKOUT;
              lock_cnt <= LOCK_INIT;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_FAIL: begin
          // The press that leaves FAIL is already the first digit of the next attempt.
          if (press) begin
            entry <= put_digit(entry, 2'd0, SW);
            idx   <= 2'd1;
            state <= ST_ENTRY;
          end
        end
        ST_OPEN: begin
          if (press) begin
            idx   <= '0;
            state <= change ? ST_NEWCODE : ST_ENTRY;
          end
        end
        ST_NEWCODE: begin
          if (press) begin
            entry <= put_digit(entry, idx, SW);
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              code  <= put_digit(entry, 2'd3, SW);
              state <= ST_ENTRY;
            end
          end
        end
        ST_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state    <= ST_ENTRY;
            fail_cnt <= '0;
            idx      <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

  always_comb begin
    HEX3       = BLANK;
    HEX2       = BLANK;
    HEX1       = BLANK;
    HEX0       = BLANK;
    unlocked   = 1'b0;
    locked_out = 1'b0;
    case (state)
      ST_ENTRY, ST_NEWCODE: begin
        if (idx > 2'd0) HEX3 = seg(entry[15:12]);
        if (idx > 2'd1) HEX2 = seg(entry[11:8]);
        if (idx > 2'd2) HEX1 = seg(entry[7:4]);
      end
      ST_OPEN: begin
        HEX3     = 7'h40;
        HEX2     = 7'h0C;
        HEX1     = 7'h06;
        HEX0     = 7'h2B;
        unlocked = 1'b1;
      end
      ST_FAIL: begin
        HEX3 = 7'h0E;
        HEX2 = 7'h08;
        HEX1 = 7'h79;
        HEX0 = 7'h47;
      end
      ST_LOCKOUT: begin
        HEX3       = 7'h3F;
        HEX2       = 7'h3F;
        HEX1       = 7'h3F;
        HEX0       = 7'h3F;
        locked_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_password_ctrl.sv
// Directed bench for password_ctrl: expected display/status tuples are queued
// as each step is driven and popped when the DUT output is sampled.
module tb_password_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       change = 1'b0;
  logic [3:0] SW = '0;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;
  logic       unlocked, locked_out;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] B = 7'h7F;
  localparam logic [29:0] RESET_V = {B, B, B, B, 1'b0, 1'b0};
  localparam logic [29:0] OPEN_V  = {7'h40, 7'h0C, 7'h06, 7'h2B, 1'b1, 1'b0};
  localparam logic [29:0] FAIL_V  = {7'h0E, 7'h08, 7'h79, 7'h47, 1'b0, 1'b0};
  localparam logic [29:0] LOCK_V  = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b1};

  typedef struct {
    string       tag;
    logic [29:0] val;
  } exp_t;
  exp_t sb[$];

  password_ctrl #(.CODE(16'h1234), .MAX_FAILS(3), .LOCK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .load(load), .change(change), .SW(SW),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] ent(input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] c);
    return {a, b, c, B, 1'b0, 1'b0};
  endfunction

  task automatic expect_out(input string tag, input logic [29:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [29:0] obs;
    e   = sb.pop_front();
    obs = {HEX3, HEX2, HEX1, HEX0, unlocked, locked_out};
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // One-cycle press; returns at the negedge after the sampling posedge.
  task automatic press(input logic [3:0] d, input logic chg);
    @(negedge clk);
    SW = d;
    change = chg;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    change = 1'b0;
  endtask

  task automatic press_chk(input logic [3:0] d, input logic chg, input string tag,
                           input logic [29:0] v);
    expect_out(tag, v);
    press(d, chg);
    check_out();
  endtask

  // Four digits, then CHECK (all blank) and the outcome one cycle later.
  task automatic attempt(input logic [15:0] c, input string tag, input logic [29:0] res);
    press(c[15:12], 1'b0);
    press(c[11:8], 1'b0);
    press(c[7:4], 1'b0);
    expect_out({tag, "_check"}, RESET_V);
    press(c[3:0], 1'b0);
    check_out();
    expect_out(tag, res);
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out(tag, RESET_V);
    check_out();
  endtask

  task automatic lockout_phase(input string tag);
    int n;
    n = 0;
    expect_out({tag, "_disp"}, LOCK_V);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check_out();
      if (locked_out) n++;
      SW = 4'h1;
      load = (i < 6) ? ((i % 2) == 1) : 1'b0;
    end
    checks++;
    assert (n == 8) else begin
      errors++;
      $error("FAIL %s_len observed=%0d expected=%0d", tag, n, 8);
    end
    expect_out({tag, "_after"}, RESET_V);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset("reset0");

    press_chk(4'h1, 1'b0, "d1", ent(7'h79, B, B));
    press_chk(4'h2, 1'b0, "d2", ent(7'h79, 7'h24, B));
    press_chk(4'h3, 1'b0, "d3", ent(7'h79, 7'h24, 7'h30));
    expect_out("d4_check", RESET_V);
    press(4'h4, 1'b0);
    check_out();
    expect_out("open1", OPEN_V);
    @(negedge clk);
    check_out();

    press_chk(4'h7, 1'b0, "relock1", RESET_V);
    attempt(16'h5555, "fail1", FAIL_V);
    press_chk(4'h1, 1'b0, "fail_next_digit", ent(7'h79, B, B));
    press(4'h5, 1'b0);
    press(4'h5, 1'b0);
    expect_out("fail2_check", RESET_V);
    press(4'h5, 1'b0);
    check_out();
    expect_out("fail2", FAIL_V);
    @(negedge clk);
    check_out();
    press_chk(4'h5, 1'b0, "fail3_d0", ent(7'h12, B, B));
    press(4'h5, 1'b0);
    press(4'h5, 1'b0);
    press(4'h5, 1'b0);
    lockout_phase("lock1");
    attempt(16'h1234, "open_after_lock", OPEN_V);

    press_chk(4'h0, 1'b1, "newcode_enter", RESET_V);
    press_chk(4'h9, 1'b0, "nc_d1", ent(7'h10, B, B));
    press(4'h8, 1'b0);
    press(4'h7, 1'b0);
    expect_out("nc_done", RESET_V);
    press(4'h6, 1'b0);
    check_out();
    attempt(16'h1234, "old_code_fails", FAIL_V);
    attempt(16'h9876, "new_code_opens", OPEN_V);

    press_chk(4'h0, 1'b0, "relock2", RESET_V);
    @(negedge clk);
    SW = 4'h2;
    load = 1'b1;
    repeat (10) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    expect_out("hold_one_digit", ent(7'h24, B, B));
    check_out();

    press_chk(4'h3, 1'b0, "mid_d2", ent(7'h24, 7'h30, B));
    do_reset("reset_mid_entry");
    attempt(16'h1234, "code_reverted1", OPEN_V);

    press_chk(4'h0, 1'b1, "newcode2", RESET_V);
    press(4'h9, 1'b0);
    press(4'h8, 1'b0);
    do_reset("reset_newcode");
    attempt(16'h1234, "code_reverted2", OPEN_V);

    press(4'h0, 1'b0);
    attempt(16'h0000, "lk_f1", FAIL_V);
    attempt(16'h0000, "lk_f2", FAIL_V);
    press(4'h0, 1'b0);
    press(4'h0, 1'b0);
    press(4'h0, 1'b0);
    press(4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    expect_out("lk_in_lockout", LOCK_V);
    check_out();
    do_reset("reset_lockout");
    attempt(16'h1234, "code_reverted3", OPEN_V);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
